oh_par2ser_ctrl: RTL

Parallel-to-serial transmitter with valid/ready load handshake and beat counter. It sits directly upstream of the serial-to-parallel receive shifter. It accepts a PW-bit word, emits it SW bits per beat, and advances only when the downstream `shift` qualifies a beat. The beat count per word is programmable, so short packets do not need padding to PW.

---
 rtl/oh_par2ser_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/oh_par2ser_ctrl.sv
// rtl/oh_par2ser_ctrl.sv - parallel-to-serial transmitter with load handshake and beat counter
module oh_par2ser_ctrl #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int CW = $clog2(PW/SW)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [PW-1:0] din,
  input  logic          load,
  output logic          ready,
  input  logic [CW:0]   datasize,
  input  logic          lsbfirst,
  input  logic          shift,
  output logic [SW-1:0] dout,
  output logic          access_out,
  output logic          done
);

  localparam int NB = PW / SW;
  localparam logic [CW:0] NB_C = NB[CW:0];
  localparam logic [CW:0] ONE  = 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] sreg_q, sreg_d;
  logic [CW:0]   count_q, count_d;
  logic [CW:0]   eff_size;
  logic          lsb_q, lsb_d;
  logic          done_q, done_d;
  logic          last_beat;
  logic          accept;

  // Zero or oversize requests fall back to a full word.
  assign eff_size  = (datasize == '0 || datasize > NB_C) ? NB_C : datasize;
  assign last_beat = (state_q == SEND) && shift && (count_q == ONE);
  assign ready     = (state_q == IDLE) || last_beat;
  assign accept    = load && ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
      lsb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      lsb_q   <= lsb_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    lsb_d   = lsb_q;
    done_d  = last_beat;
    if (accept) begin
      sreg_d  = din;
      lsb_d   = lsbfirst;
      count_d = eff_size;
      state_d = SEND;
    end else if (state_q == SEND && shift) begin
      if (last_beat) begin
        state_d = IDLE;
      end else begin
        sreg_d  = lsb_q ? (sreg_q >> SW) : (sreg_q << SW);
        count_d = count_q - ONE;
      end
    end
  end

  always_comb begin
    access_out = (state_q == SEND);
    done       = done_q;
    dout       = '0;
    if (state_q == SEND) begin
      dout = lsb_q ? sreg_q[SW-1:0] : sreg_q[PW-1:PW-SW];
    end
  end

endmodule
